// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control for the five-stage core, plus data-memory wait sequencing.
// Build option: define HAZARD_PERF_CNT_EN to add the StallCnt/FlushCnt performance counters.

module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] Rs1B,
    input  logic [4:0] Rs2B,
    input  logic [4:0] Rs1C,
    input  logic [4:0] Rs2C,
    input  logic [4:0] RdC,
    input  logic       RegWriteC,
    input  logic [1:0] ResultSrcC,
    input  logic [4:0] RdD,
    input  logic       RegWriteD,
    input  logic [4:0] RdE,
    input  logic       RegWriteE,
    input  logic       PCSrcC,
    input  logic       MemReqD,
    input  logic       MemReadyD,
    output logic       StallA,
    output logic       StallB,
    output logic       StallC,
    output logic       StallD,
    output logic       FlushB,
    output logic       FlushC,
    output logic       FlushE,
    output logic [1:0] ForwardAC,
    output logic [1:0] ForwardBC,
    output logic       MemTimeoutErr
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] StallCnt,
    output logic [CNT_WIDTH-1:0] FlushCnt
`endif
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t     state_r;
    state_t     stateNext_s;
    logic [7:0] toutCnt_r;
    logic [7:0] toutCntNext_s;
    logic       freeze_s;
    logic       loadUse_s;

    // A load is recognised from ResultSrcC alone, so the execute-stage write enable is not needed.
    logic unusedRegWrite_s;
    assign unusedRegWrite_s = RegWriteC;

    // Memory-stage result wins over writeback; x0 never forwards.
    function automatic logic [1:0] fwdSel(input logic [4:0] rs, input logic wrD, input logic [4:0] rdD,
                                          input logic wrE, input logic [4:0] rdE);
        logic [1:0] sel;
        sel = 2'b00;
        if (wrD && (rdD != 5'd0) && (rdD == rs)) begin
            sel = 2'b10;
        end else if (wrE && (rdE != 5'd0) && (rdE == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign freeze_s  = MemReqD & ~MemReadyD;
    assign loadUse_s = (ResultSrcC == 2'b01) && (RdC != 5'd0) && ((RdC == Rs1B) || (RdC == Rs2B));

    // State register: RUN / MEM_WAIT.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_r <= RUN;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // Next-state logic for the memory-wait sequencer.
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            RUN: begin
                if (freeze_s) begin
                    stateNext_s = MEM_WAIT;
                end else begin
                    stateNext_s = RUN;
                end
            end
            MEM_WAIT: begin
                if (MemReadyD) begin
                    stateNext_s = RUN;
                end else begin
                    stateNext_s = MEM_WAIT;
                end
            end
            default: stateNext_s = RUN;
        endcase
    end

    // Stall, flush and forward decode; priority is freeze, then taken branch, then load-use.
    always_comb begin
        StallA    = 1'b0;
        StallB    = 1'b0;
        StallC    = 1'b0;
        StallD    = 1'b0;
        FlushB    = 1'b0;
        FlushC    = 1'b0;
        FlushE    = 1'b0;
        ForwardAC = 2'b00;
        ForwardBC = 2'b00;
        if (rst_n) begin
            ForwardAC = 2'b00;
            ForwardBC = 2'b00;
        end else begin
            ForwardAC = fwdSel(Rs1C, RegWriteD, RdD, RegWriteE, RdE);
            ForwardBC = fwdSel(Rs2C, RegWriteD, RdD, RegWriteE, RdE);
            if (freeze_s) begin
                StallA = 1'b1;
                StallB = 1'b1;
                StallC = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end else if (PCSrcC) begin
                FlushB = 1'b1;
                FlushC = 1'b1;
            end else if (loadUse_s) begin
                StallA = 1'b1;
                StallB = 1'b1;
                FlushC = 1'b1;
            end else begin
                StallA = 1'b0;
            end
        end
    end

    // Saturating wait counter; it stops at the limit so the error flag can only be set, never wrap.
    always_comb begin
        toutCntNext_s = toutCnt_r;
        if (toutCnt_r >= TIMEOUT_LIM) begin
            toutCntNext_s = TIMEOUT_LIM;
        end else begin
            toutCntNext_s = toutCnt_r + 8'd1;
        end
    end

    // Timeout counter and sticky error flag.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            toutCnt_r     <= 8'd0;
            MemTimeoutErr <= 1'b0;
        end else if (state_r == RUN) begin
            toutCnt_r     <= 8'd0;
            MemTimeoutErr <= MemTimeoutErr;
        end else begin
            toutCnt_r <= toutCntNext_s;
            if (toutCntNext_s == TIMEOUT_LIM) begin
                MemTimeoutErr <= 1'b1;
            end else begin
                MemTimeoutErr <= MemTimeoutErr;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Performance counters: stalled cycles and cycles with any bubble inserted; both wrap.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (StallA) begin
                StallCnt <= StallCnt + CNT_WIDTH'(1);
            end else begin
                StallCnt <= StallCnt;
            end
            if (FlushB | FlushC | FlushE) begin
                FlushCnt <= FlushCnt + CNT_WIDTH'(1);
            end else begin
                FlushCnt <= FlushCnt;
            end
        end
    end
`else
    logic [CNT_WIDTH-1:0] unusedCnt_s;
    assign unusedCnt_s = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, multi-cycle sequences and a randomized
// phase against a rule-level reference model. Counter checks follow HAZARD_PERF_CNT_EN.

module tb_hazard_ctrl;

    localparam int MEM_TO = 10;

    logic clk;
    logic rst_n;
    logic [4:0] Rs1B, Rs2B, Rs1C, Rs2C, RdC, RdD, RdE;
    logic RegWriteC, RegWriteD, RegWriteE, PCSrcC, MemReqD, MemReadyD;
    logic [1:0] ResultSrcC;
    logic StallA, StallB, StallC, StallD, FlushB, FlushC, FlushE, MemTimeoutErr;
    logic [1:0] ForwardAC, ForwardBC;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] StallCnt, FlushCnt;
`endif

    hazard_ctrl #(.MEM_TIMEOUT(MEM_TO), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1B(Rs1B), .Rs2B(Rs2B), .Rs1C(Rs1C), .Rs2C(Rs2C), .RdC(RdC),
        .RegWriteC(RegWriteC), .ResultSrcC(ResultSrcC),
        .RdD(RdD), .RegWriteD(RegWriteD), .RdE(RdE), .RegWriteE(RegWriteE),
        .PCSrcC(PCSrcC), .MemReqD(MemReqD), .MemReadyD(MemReadyD),
        .StallA(StallA), .StallB(StallB), .StallC(StallC), .StallD(StallD),
        .FlushB(FlushB), .FlushC(FlushC), .FlushE(FlushE),
        .ForwardAC(ForwardAC), .ForwardBC(ForwardBC),
        .MemTimeoutErr(MemTimeoutErr)
`ifdef HAZARD_PERF_CNT_EN
        , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {StallA,B,C,D, FlushB,C,E, ForwardAC, ForwardBC}
    logic [10:0] obsOut;
    assign obsOut = {StallA, StallB, StallC, StallD, FlushB, FlushC, FlushE, ForwardAC, ForwardBC};

    int passCnt = 0;
    int totalCnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [4:0] rs1B, rs2B, rs1C, rs2C, rdC;
        logic [1:0] resSrc;
        logic [4:0] rdD;
        logic       wD;
        logic [4:0] rdE;
        logic       wE, pc, req, rdy;
        logic [10:0] expOut;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkVec(logic [4:0] rs1B, logic [4:0] rs2B, logic [4:0] rs1C, logic [4:0] rs2C,
                                   logic [4:0] rdC, logic [1:0] resSrc, logic [4:0] rdD, logic wD,
                                   logic [4:0] rdE, logic wE, logic pc, logic req, logic rdy, logic [10:0] expOut);
        vec_t v;
        v.rs1B = rs1B; v.rs2B = rs2B; v.rs1C = rs1C; v.rs2C = rs2C; v.rdC = rdC; v.resSrc = resSrc;
        v.rdD = rdD; v.wD = wD; v.rdE = rdE; v.wE = wE; v.pc = pc; v.req = req; v.rdy = rdy;
        v.expOut = expOut;
        return v;
    endfunction

    task automatic clearInputs();
        Rs1B = 5'd0; Rs2B = 5'd0; Rs1C = 5'd0; Rs2C = 5'd0; RdC = 5'd0; RdD = 5'd0; RdE = 5'd0;
        RegWriteC = 1'b0; RegWriteD = 1'b0; RegWriteE = 1'b0; ResultSrcC = 2'b00;
        PCSrcC = 1'b0; MemReqD = 1'b0; MemReadyD = 1'b0;
    endtask

    task automatic applyVec(input vec_t v);
        Rs1B = v.rs1B; Rs2B = v.rs2B; Rs1C = v.rs1C; Rs2C = v.rs2C; RdC = v.rdC; ResultSrcC = v.resSrc;
        RdD = v.rdD; RegWriteD = v.wD; RdE = v.rdE; RegWriteE = v.wE; RegWriteC = v.resSrc == 2'b01;
        PCSrcC = v.pc; MemReqD = v.req; MemReadyD = v.rdy;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Freeze for n cycles, then return ready; the error flag appears once MEM_TO wait-state cycles have elapsed.
    task automatic freezeRun(input int n, input string tag);
        clearInputs();
        MemReqD = 1'b1;
        MemReadyD = 1'b0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            check($sformatf("%s_frz%0d", tag, k), {obsOut, MemTimeoutErr},
                  {11'b1111_001_00_00, (k >= MEM_TO + 2)});
            nextCycle();
        end
        MemReadyD = 1'b1;
        @(negedge clk);
        check($sformatf("%s_ready", tag), {obsOut, MemTimeoutErr}, {11'd0, (n - 1 >= MEM_TO)});
        nextCycle();
        clearInputs();
        @(negedge clk);
        check($sformatf("%s_after", tag), {obsOut, MemTimeoutErr}, {11'd0, (n >= MEM_TO)});
        nextCycle();
    endtask

    // Reference model: outputs derived from the hazard rules; wait tracking in plain integers.
    bit inWait;
    int waitCycles;
    bit errM;
    logic [31:0] stallM, flushM;

    function automatic logic [1:0] refFwd(input logic [4:0] rs);
        logic [4:0] rd[2];
        logic       wr[2];
        logic [1:0] code[2];
        logic [1:0] r;
        rd[0] = RdD; wr[0] = RegWriteD; code[0] = 2'b10;
        rd[1] = RdE; wr[1] = RegWriteE; code[1] = 2'b01;
        r = 2'b00;
        if (rs != 5'd0)
            for (int p = 1; p >= 0; p--)
                if (wr[p] && rd[p] == rs) r = code[p];
        return r;
    endfunction

    function automatic logic [10:0] refOut();
        bit frz, br, lu;
        logic [3:0] st;
        logic [2:0] fl;
        if (rst_n) return 11'd0;
        frz = MemReqD && !MemReadyD;
        br  = PCSrcC && !frz;
        lu  = ResultSrcC == 2'b01 && RdC != 5'd0 && (RdC == Rs1B || RdC == Rs2B) && !frz && !br;
        st  = frz ? 4'b1111 : (lu ? 4'b1100 : 4'b0000);
        fl  = {br, br || lu, frz};
        return {st, fl, refFwd(Rs1C), refFwd(Rs2C)};
    endfunction

    initial begin
        logic [10:0] expO;
        logic [31:0] s0, f0;
        s0 = 32'd0; f0 = 32'd0;

        // Reset held with inputs that would otherwise freeze and forward.
        clearInputs();
        rst_n = 1'b1;
        MemReqD = 1'b1; Rs1C = 5'd5; RdD = 5'd5; RegWriteD = 1'b1; PCSrcC = 1'b1;
        @(negedge clk);
        check("reset_outs", {obsOut, MemTimeoutErr}, 12'd0);
`ifdef HAZARD_PERF_CNT_EN
        check("reset_cnt", {StallCnt, FlushCnt}, 64'd0);
`endif
        nextCycle();
        rst_n = 1'b0;
        clearInputs();
        @(negedge clk);
        check("idle", {obsOut, MemTimeoutErr}, 12'd0);
        nextCycle();

        vecs.push_back(mkVec(0,0,5,0,0,2'b00,5,1,5,1,0,0,0, 11'b0000_000_10_00));
        vecs.push_back(mkVec(0,0,5,0,0,2'b00,0,1,5,1,0,0,0, 11'b0000_000_01_00));
        vecs.push_back(mkVec(0,0,7,7,0,2'b00,7,0,7,1,0,0,0, 11'b0000_000_01_01));
        vecs.push_back(mkVec(0,0,0,0,0,2'b00,0,1,0,1,0,0,0, 11'b0000_000_00_00));
        vecs.push_back(mkVec(0,3,0,0,3,2'b01,0,0,0,0,0,0,0, 11'b1100_010_00_00));
        vecs.push_back(mkVec(9,0,0,4,9,2'b01,4,1,0,0,0,0,0, 11'b1100_010_00_10));
        vecs.push_back(mkVec(0,0,0,0,0,2'b01,0,0,0,0,0,0,0, 11'b0000_000_00_00));
        vecs.push_back(mkVec(3,0,0,0,3,2'b10,0,0,0,0,0,0,0, 11'b0000_000_00_00));
        vecs.push_back(mkVec(0,3,0,0,3,2'b01,0,0,0,0,1,0,0, 11'b0000_110_00_00));
        vecs.push_back(mkVec(0,3,0,0,3,2'b01,0,0,0,0,0,1,1, 11'b1100_010_00_00));
        vecs.push_back(mkVec(0,0,5,0,0,2'b00,5,1,0,0,1,1,0, 11'b1111_001_10_00));
        vecs.push_back(mkVec(0,0,0,0,0,2'b00,0,0,0,0,0,1,1, 11'b0000_000_00_00));
        for (int i = 0; i < vecs.size(); i++) begin
            applyVec(vecs[i]);
            @(negedge clk);
            check($sformatf("vec%0d", i), {obsOut, MemTimeoutErr}, {vecs[i].expOut, 1'b0});
            nextCycle();
        end

        // Load-use: one stall cycle, load reaches D, then the consumer forwards from E.
        clearInputs();
        ResultSrcC = 2'b01; RdC = 5'd3; Rs2B = 5'd3;
        @(negedge clk);
        check("lu_stall", obsOut, 11'b1100_010_00_00);
        nextCycle();
        clearInputs();
        Rs2B = 5'd3; RdD = 5'd3; RegWriteD = 1'b1;
        @(negedge clk);
        check("lu_inD", obsOut, 11'd0);
        nextCycle();
        clearInputs();
        Rs2C = 5'd3; RdE = 5'd3; RegWriteE = 1'b1;
        @(negedge clk);
        check("lu_fwdE", obsOut, 11'b0000_000_00_01);
        nextCycle();

        // Four-cycle freeze with counter deltas.
        clearInputs();
`ifdef HAZARD_PERF_CNT_EN
        @(negedge clk);
        s0 = StallCnt; f0 = FlushCnt;
        nextCycle();
`endif
        freezeRun(4, "frz4");
`ifdef HAZARD_PERF_CNT_EN
        check("stallcnt_delta", StallCnt - s0, 32'd4);
        check("flushcnt_delta", FlushCnt - f0, 32'd4);
`endif

        // Timeout: flag rises after the tenth wait-state cycle and is sticky.
        freezeRun(12, "tout");

        // Reset in the middle of a wait clears everything asynchronously.
        clearInputs();
        MemReqD = 1'b1; Rs1C = 5'd5; RdD = 5'd5; RegWriteD = 1'b1;
        nextCycle();
        nextCycle();
        nextCycle();
        #2;
        check("midwait_frozen", {obsOut, MemTimeoutErr}, {11'b1111_001_10_00, 1'b1});
        rst_n = 1'b1;
        #1;
        check("rst_async", {obsOut, MemTimeoutErr}, 12'd0);
        nextCycle();
        rst_n = 1'b0;
        clearInputs();
        freezeRun(12, "postrst");

        // Randomized phase against the reference model.
        inWait = 1'b0; waitCycles = 0; errM = 1'b0; stallM = 32'd0; flushM = 32'd0;
        for (int i = 0; i < 400; i++) begin
            rst_n      = (i == 0) || ($urandom_range(0, 59) == 0);
            Rs1B       = 5'($urandom_range(0, 3));
            Rs2B       = 5'($urandom_range(0, 3));
            Rs1C       = 5'($urandom_range(0, 3));
            Rs2C       = 5'($urandom_range(0, 3));
            RdC        = 5'($urandom_range(0, 3));
            RdD        = 5'($urandom_range(0, 3));
            RdE        = 5'($urandom_range(0, 3));
            ResultSrcC = 2'($urandom_range(0, 3));
            RegWriteC  = 1'($urandom_range(0, 1));
            RegWriteD  = 1'($urandom_range(0, 1));
            RegWriteE  = 1'($urandom_range(0, 1));
            PCSrcC     = ($urandom_range(0, 4) == 0);
            MemReqD    = ($urandom_range(0, 2) == 0);
            MemReadyD  = ($urandom_range(0, 5) == 0);
            @(negedge clk);
            expO = refOut();
            check($sformatf("rand%0d", i), {obsOut, MemTimeoutErr}, {expO, errM && !rst_n});
            @(posedge clk);
            if (rst_n) begin
                inWait = 1'b0; waitCycles = 0; errM = 1'b0; stallM = 32'd0; flushM = 32'd0;
            end else begin
                stallM = stallM + {31'd0, expO[10]};
                flushM = flushM + {31'd0, |expO[6:4]};
                if (inWait) begin
                    waitCycles++;
                    if (waitCycles >= MEM_TO) errM = 1'b1;
                    inWait = !MemReadyD;
                end else begin
                    waitCycles = 0;
                    inWait = MemReqD && !MemReadyD;
                end
            end
            #1;
        end
`ifdef HAZARD_PERF_CNT_EN
        check("rand_stallcnt", StallCnt, stallM);
        check("rand_flushcnt", FlushCnt, flushM);
`endif

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RISC-V core (stages A fetch, B decode, C execute, D memory, E writeback). It watches register addresses and control bits from stages B–E plus the data-memory handshake. It drives stall/flush enables for the stage registers and forwarding selects for the execute-stage operand muxes. A small state machine sequences data-memory wait freezes and watches for wait timeouts.

## Interface
- MEM_TIMEOUT, 255: maximum consecutive MEM_WAIT cycles before the error flag sets (1..255).
- CNT_WIDTH, 32: width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, **active-high** (the name follows the codebase; polarity is fixed high).
- Rs1B, Rs2B  in  5 each  source registers of the instruction in decode.
- Rs1C, Rs2C, RdC  in  5 each  sources and destination of the instruction in execute.
- RegWriteC  in  1  execute-stage register write.
- ResultSrcC  in  2  execute-stage result select; 2'b01 = load.
- RdD, RegWriteD  in  5/1  memory-stage destination and write enable.
- RdE, RegWriteE  in  5/1  writeback-stage destination and write enable.
- PCSrcC  in  1  taken branch or jump resolved in execute.
- MemReqD, MemReadyD  in  1/1  data-memory request and ready.
- StallA, StallB, StallC, StallD  out  1 each  hold the corresponding stage register.
- FlushB, FlushC, FlushE  out  1 each  load a bubble into the stage register.
- ForwardAC, ForwardBC  out  2 each  operand select: 00 register file, 10 from D, 01 from E.
- MemTimeoutErr  out  1  sticky timeout flag.
- StallCnt, FlushCnt  out  CNT_WIDTH each  present only with HAZARD_PERF_CNT_EN.

## Operation
- States: RUN, MEM_WAIT. The reset state is RUN.
- RUN → MEM_WAIT when MemReqD=1 and MemReadyD=0.
- MEM_WAIT → RUN on the first cycle with MemReadyD=1.
- Freeze: while the condition MemReqD & !MemReadyD holds, StallA/B/C/D=1 and FlushE=1. All other stall/flush outputs are 0. This is combinational, so it also applies in the entry cycle.
- Flush: if PCSrcC=1 and there is no freeze, FlushB=FlushC=1 and StallA=StallB=0. Flush wins over a load-use stall.
- Load-use: the condition is ResultSrcC==01 & RdC!=0 & (RdC==Rs1B | RdC==Rs2B). When it holds with no freeze and no flush, StallA=StallB=1 and FlushC=1 for one cycle.
- Forwarding for operand A:
  - 10 if RegWriteD & RdD!=0 & RdD==Rs1C.
  - Otherwise 01 if RegWriteE & RdE!=0 & RdE==Rs1C.
  - Otherwise 00.
  - D takes priority over E. ForwardBC is identical, using Rs2C.
- Forward selects stay valid during a freeze.
- Register x0 never generates a hazard or a forward.
- Timeout counter (8 bits):
  - Clears in RUN.
  - Increments each MEM_WAIT cycle and saturates at MEM_TIMEOUT.
  - On reaching MEM_TIMEOUT, MemTimeoutErr sets and holds until reset.
  - The freeze continues regardless of the timeout.

## Timing
- Stall, flush and forward outputs are combinational from the inputs and the state, with zero latency.
- The state register, timeout counter, error flag and performance counters update on the rising edge of clk.
- While rst_n=1: state=RUN, counters=0, MemTimeoutErr=0, and every stall, flush and forward output is forced to 0.
- If reset is asserted mid-MEM_WAIT, the block returns to RUN immediately and asynchronously.
- A load-use stall lasts exactly one cycle: the load advances to D and is then forwarded from E.
- A MemReadyD pulse that arrives in the same cycle as MemReqD causes no freeze.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - StallCnt increments on every cycle with StallA=1.
  - FlushCnt increments on every cycle with FlushB|FlushC|FlushE=1.
  - Both counters wrap modulo 2^CNT_WIDTH and reset to 0.
- HAZARD_PERF_CNT_EN undefined: the counters and their ports are omitted entirely.

## Test plan
- Forwarding:
  - RegWriteD=1, RdD=5, Rs1C=5, with RegWriteE=1, RdE=5 → ForwardAC=10 (D takes priority).
  - Same case with RdD=0 → ForwardAC=01.
- Load-use: ResultSrcC=01, RdC=3, Rs2B=3 → StallA=StallB=FlushC=1 for exactly one cycle, then all deasserted once the load is in D.
- Branch versus load-use: PCSrcC=1 together with the load-use condition → FlushB=FlushC=1, StallA=0.
- Freeze: MemReqD=1, MemReadyD=0 for 4 cycles, then MemReadyD=1 →
  - StallA–D=1 and FlushE=1 for 4 cycles.
  - State returns to RUN.
  - StallCnt advances by 4 when the macro is on.
- Timeout:
  - Bench configured with MEM_TIMEOUT=10.
  - Stimulus: MemReadyD held 0 for 12 cycles.
  - Required: MemTimeoutErr rises after the 10th wait cycle and stays 1 after ready returns.
  - Reset then clears the flag.
- Reset mid-wait: assert rst_n during MEM_WAIT → all outputs go to 0 asynchronously; after release, the block is in RUN.
